// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator and its encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } kp_state_e;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // Column 0 / row 0 is the MSB of the one-hot vector.
    localparam logic [3:0] COL_0 = 4'b1000;
    localparam logic [3:0] COL_1 = 4'b0100;
    localparam logic [3:0] COL_2 = 4'b0010;
    localparam logic [3:0] COL_3 = 4'b0001;
    localparam logic [3:0] ROW_0 = 4'b1000;
    localparam logic [3:0] ROW_1 = 4'b0100;
    localparam logic [3:0] ROW_2 = 4'b0010;
    localparam logic [3:0] ROW_3 = 4'b0001;
    localparam logic [3:0] LINE_NONE = 4'b0000;

endpackage

// File: rtl/keypad_key_encoder.sv
// Maps a 4-bit key code to its one-hot {column, row} position on the keypad.
module keypad_key_encoder
    import keypad_pkg::*;
(
    input  logic [3:0] key_code,
    output logic [3:0] col,
    output logic [3:0] row
);

    // Key map lookup
    always_comb begin
        col = LINE_NONE;
        row = LINE_NONE;
        case (key_code)
            KEY_1: begin col = COL_0; row = ROW_0; end
            KEY_2: begin col = COL_0; row = ROW_1; end
            KEY_3: begin col = COL_0; row = ROW_2; end
            KEY_A: begin col = COL_0; row = ROW_3; end
            KEY_4: begin col = COL_1; row = ROW_0; end
            KEY_5: begin col = COL_1; row = ROW_1; end
            KEY_6: begin col = COL_1; row = ROW_2; end
            KEY_B: begin col = COL_1; row = ROW_3; end
            KEY_7: begin col = COL_2; row = ROW_0; end
            KEY_8: begin col = COL_2; row = ROW_1; end
            KEY_9: begin col = COL_2; row = ROW_2; end
            KEY_C: begin col = COL_2; row = ROW_3; end
            KEY_0: begin col = COL_3; row = ROW_0; end
            KEY_E: begin col = COL_3; row = ROW_1; end
            KEY_F: begin col = COL_3; row = ROW_2; end
            KEY_D: begin col = COL_3; row = ROW_3; end
            default: begin col = LINE_NONE; row = LINE_NONE; end
        endcase
    end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: presses a requested key for PRESS_CYCLES, then forces idle for RELEASE_CYCLES.
// Optional contact chatter model enabled by defining KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int PRESS_CYCLES   = 16,
    parameter int RELEASE_CYCLES = 8,
    parameter int BOUNCE_CYCLES  = 4
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       press_active,
    output logic       busy,
    output logic       done
);

    localparam int MAX_CYCLES = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] PRESS_LOAD   = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    kp_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       col_r;
    logic [3:0]       row_r;
    logic             done_r;
    logic [3:0]       enc_col_s;
    logic [3:0]       enc_row_s;
    logic             chatter_ok_s;

    keypad_key_encoder u_encoder (
        .key_code (key_code),
        .col      (enc_col_s),
        .row      (enc_row_s)
    );

    // Press/release sequencer with latched key position and done pulse
    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            col_r   <= LINE_NONE;
            row_r   <= LINE_NONE;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (key_valid) begin
                        col_r   <= enc_col_s;
                        row_r   <= enc_row_s;
                        cnt_r   <= PRESS_LOAD;
                        state_r <= PRESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PRESS: begin
                    if (cnt_r == CNT_ZERO) begin
                        cnt_r   <= RELEASE_LOAD;
                        state_r <= RELEASE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (cnt_r == CNT_ZERO) begin
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    cnt_r   <= CNT_ZERO;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    // The counter runs down from PRESS_LOAD, so the top BOUNCE_CYCLES values are the chatter window.
    localparam logic [CNT_W-1:0] BOUNCE_FLOOR = CNT_W'(PRESS_CYCLES - BOUNCE_CYCLES);

    logic [3:0] lfsr_r;
    logic       bounce_s;

    assign bounce_s = (state_r == PRESS) && (cnt_r >= BOUNCE_FLOOR);

    // Chatter LFSR, x^4 + x^3 + 1, advancing only inside the bounce window
    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            lfsr_r <= 4'b1001;
        end else if (bounce_s) begin
            lfsr_r <= {lfsr_r[2:0], lfsr_r[3] ^ lfsr_r[2]};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign chatter_ok_s = !bounce_s || lfsr_r[0];
`else
    assign chatter_ok_s = 1'b1;
`endif

    assign key_ready    = (state_r == IDLE);
    assign busy         = (state_r != IDLE);
    assign press_active = (state_r == PRESS);
    assign done         = done_r;

    // Same-cycle response so the scanner sees the row within the column it is driving.
    assign row_out = (press_active && (col_in == col_r) && chatter_ok_s) ? row_r : LINE_NONE;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed, table-driven bench for keypad_emulator (default build, no chatter model).
module tb_keypad_emulator;

    logic       slow_clk  = 1'b0;
    logic       rst       = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code  = 4'h0;
    logic [3:0] col_in    = 4'b0000;
    logic       key_ready;
    logic [3:0] row_out;
    logic       press_active;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] code;
        logic [3:0] col;
        logic [3:0] row;
    } vec_t;

    vec_t       vecs [16];
    logic [3:0] cols [6];

    always #5 slow_clk = ~slow_clk;

    keypad_emulator #(
        .PRESS_CYCLES   (16),
        .RELEASE_CYCLES (8),
        .BOUNCE_CYCLES  (4)
    ) dut (
        .slow_clk     (slow_clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .col_in       (col_in),
        .row_out      (row_out),
        .press_active (press_active),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Returns at posedge+1 right after the transfer edge; next negedge is press cycle 0.
    task automatic send_key(input logic [3:0] code);
        int n;
        n = 0;
        @(negedge slow_clk);
        while (!key_ready && n < 100) begin
            @(negedge slow_clk);
            n++;
        end
        chk1("send_ready", key_ready, 1'b1);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge slow_clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge slow_clk);
        while (busy && n < 100) begin
            @(negedge slow_clk);
            n++;
        end
        chk1("wait_idle_busy", busy, 1'b0);
    endtask

    initial begin
        logic [3:0] exp_row;
        logic [3:0] rot [4];

        vecs[0]  = '{4'h1, 4'b1000, 4'b1000};
        vecs[1]  = '{4'h2, 4'b1000, 4'b0100};
        vecs[2]  = '{4'h3, 4'b1000, 4'b0010};
        vecs[3]  = '{4'hA, 4'b1000, 4'b0001};
        vecs[4]  = '{4'h4, 4'b0100, 4'b1000};
        vecs[5]  = '{4'h5, 4'b0100, 4'b0100};
        vecs[6]  = '{4'h6, 4'b0100, 4'b0010};
        vecs[7]  = '{4'hB, 4'b0100, 4'b0001};
        vecs[8]  = '{4'h7, 4'b0010, 4'b1000};
        vecs[9]  = '{4'h8, 4'b0010, 4'b0100};
        vecs[10] = '{4'h9, 4'b0010, 4'b0010};
        vecs[11] = '{4'hC, 4'b0010, 4'b0001};
        vecs[12] = '{4'h0, 4'b0001, 4'b1000};
        vecs[13] = '{4'hE, 4'b0001, 4'b0100};
        vecs[14] = '{4'hF, 4'b0001, 4'b0010};
        vecs[15] = '{4'hD, 4'b0001, 4'b0001};
        cols[0] = 4'b1000;
        cols[1] = 4'b0100;
        cols[2] = 4'b0010;
        cols[3] = 4'b0001;
        cols[4] = 4'b0000;
        cols[5] = 4'b1100;
        rot[0] = 4'b1000;
        rot[1] = 4'b0100;
        rot[2] = 4'b0010;
        rot[3] = 4'b0001;

        // Reset state
        #2;
        chk1("rst_key_ready", key_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_press", press_active, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk4("rst_row", row_out, 4'b0000);
        @(negedge slow_clk);
        rst = 1'b1;

        // Full key map, including non-one-hot and zero column drives
        for (int i = 0; i < 16; i++) begin
            send_key(vecs[i].code);
            for (int c = 0; c < 6; c++) begin
                @(negedge slow_clk);
                col_in = cols[c];
                #1;
                exp_row = (cols[c] == vecs[i].col) ? vecs[i].row : 4'b0000;
                chk4($sformatf("map_key%h_col%b", vecs[i].code, cols[c]), row_out, exp_row);
            end
            chk1($sformatf("map_key%h_press", vecs[i].code), press_active, 1'b1);
            col_in = 4'b0000;
            wait_idle();
        end

        // Key 5 with rotating columns: exact press/release lengths and done timing
        send_key(4'h5);
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge slow_clk);
            col_in = rot[cyc % 4];
            #1;
            exp_row = (cyc < 16 && rot[cyc % 4] == 4'b0100) ? 4'b0100 : 4'b0000;
            chk4($sformatf("k5_row_c%0d", cyc), row_out, exp_row);
            chk1($sformatf("k5_press_c%0d", cyc), press_active, (cyc < 16) ? 1'b1 : 1'b0);
            chk1($sformatf("k5_busy_c%0d", cyc), busy, (cyc < 24) ? 1'b1 : 1'b0);
            chk1($sformatf("k5_done_c%0d", cyc), done, (cyc == 24) ? 1'b1 : 1'b0);
            chk1($sformatf("k5_ready_c%0d", cyc), key_ready, (cyc >= 24) ? 1'b1 : 1'b0);
        end
        col_in = 4'b0000;

        // Key D then key 0 back-to-back in the done cycle
        send_key(4'hD);
        col_in = 4'b0001;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge slow_clk);
            #1;
            chk4($sformatf("kd_row_c%0d", cyc), row_out, (cyc < 16) ? 4'b0001 : 4'b0000);
        end
        chk1("b2b_done", done, 1'b1);
        chk1("b2b_ready", key_ready, 1'b1);
        key_valid = 1'b1;
        key_code  = 4'h0;
        @(posedge slow_clk);
        #1;
        key_valid = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge slow_clk);
            #1;
            chk4($sformatf("k0_row_c%0d", cyc), row_out, 4'b1000);
        end
        col_in = 4'b0000;
        wait_idle();

        // key_valid held through busy; code change mid-press is ignored
        @(negedge slow_clk);
        key_valid = 1'b1;
        key_code  = 4'h7;
        @(posedge slow_clk);
        #1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge slow_clk);
            if (cyc == 5) key_code = 4'h9;
            col_in = (cyc % 2 == 1) ? 4'b1000 : 4'b0010;
            #1;
            if (cyc < 16) begin
                exp_row = (cyc % 2 == 1) ? 4'b0000 : 4'b1000;
                chk4($sformatf("k7_row_c%0d", cyc), row_out, exp_row);
            end
        end
        chk1("k9_done", done, 1'b1);
        chk1("k9_ready", key_ready, 1'b1);
        @(posedge slow_clk);
        #1;
        key_valid = 1'b0;
        col_in = 4'b0010;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge slow_clk);
            #1;
            chk4($sformatf("k9_row_c%0d", cyc), row_out, 4'b0010);
        end
        col_in = 4'b0000;
        wait_idle();

        // Asynchronous reset in the middle of a press
        send_key(4'h1);
        col_in = 4'b1000;
        @(negedge slow_clk);
        #1;
        chk4("rstmid_row_before", row_out, 4'b1000);
        #1;
        rst = 1'b0;
        #1;
        chk4("rstmid_row", row_out, 4'b0000);
        chk1("rstmid_ready", key_ready, 1'b1);
        chk1("rstmid_busy", busy, 1'b0);
        chk1("rstmid_press", press_active, 1'b0);
        chk1("rstmid_done", done, 1'b0);
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge slow_clk);
            chk1($sformatf("rstheld_done_c%0d", cyc), done, 1'b0);
        end
        rst = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge slow_clk);
            #1;
            chk1($sformatf("rstpost_done_c%0d", cyc), done, 1'b0);
            chk4($sformatf("rstpost_row_c%0d", cyc), row_out, 4'b0000);
        end
        col_in = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
